// File: rtl/additionneur_serie_param.sv
// Digit-serial adder/subtractor: DIGIT bits per clock over WIDTH/DIGIT cycles,
// framed by a start/busy/done handshake; results held until the next completion.
module additionneur_serie_param #(
    parameter int WIDTH = 8,
    parameter int DIGIT = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             sub,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             rin,
    output logic [WIDTH-1:0] s,
    output logic             rout,
    output logic             ovf,
    output logic             busy,
    output logic             done
);

    localparam int N     = WIDTH / DIGIT;
    localparam int CNT_W = (N > 1) ? $clog2(N) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(N - 1);

    if (WIDTH < 2 || DIGIT < 1 || (WIDTH % DIGIT) != 0) begin : g_param_check
        $error("additionneur_serie_param: WIDTH must be >= 2 and a multiple of DIGIT");
    end

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] op_a_q, op_a_d;
    logic [WIDTH-1:0] op_b_q, op_b_d;
    logic [WIDTH-1:0] s_q, s_d;
    logic             carry_q, carry_d;
    logic             sub_q, sub_d;
    logic             rout_q, rout_d;
    logic             ovf_q, ovf_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic [DIGIT-1:0] dig_sum;
    logic             dig_cout;
    logic             dig_cmsb;
    logic [WIDTH-1:0] a_shift;

    // One digit of ripple carry; dig_cmsb is the carry into the digit's top bit,
    // which on the last digit is the carry into bit WIDTH-1 needed for ovf.
    always_comb begin
        logic c;
        c        = carry_q;
        dig_cmsb = carry_q;
        dig_sum  = '0;
        for (int i = 0; i < DIGIT; i++) begin
            dig_cmsb   = c;
            dig_sum[i] = op_a_q[i] ^ op_b_q[i] ^ c;
            c          = (op_a_q[i] & op_b_q[i]) | (c & (op_a_q[i] ^ op_b_q[i]));
        end
        dig_cout = c;
    end

    // op_a doubles as the result shift register: sum digits enter at the MSB
    // while operand digits leave at the LSB, so no separate accumulator is kept.
    if (DIGIT == WIDTH) begin : g_single_digit
        assign a_shift = dig_sum;
    end else begin : g_multi_digit
        assign a_shift = {dig_sum, op_a_q[WIDTH-1:DIGIT]};
    end

    always_comb begin
        state_d = state_q;
        op_a_d  = op_a_q;
        op_b_d  = op_b_q;
        carry_d = carry_q;
        sub_d   = sub_q;
        cnt_d   = cnt_q;
        s_d     = s_q;
        rout_d  = rout_q;
        ovf_d   = ovf_q;

        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    op_a_d  = a;
                    op_b_d  = sub ? ~b : b;
                    carry_d = sub ? ~rin : rin;
                    sub_d   = sub;
                    cnt_d   = '0;
                    state_d = S_RUN;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_RUN: begin
                op_a_d  = a_shift;
                op_b_d  = op_b_q >> DIGIT;
                carry_d = dig_cout;
                cnt_d   = cnt_q + 1'b1;
                if (cnt_q == LAST) begin
                    s_d     = a_shift;
                    rout_d  = dig_cout ^ sub_q;
                    ovf_d   = dig_cmsb ^ dig_cout;
                    state_d = S_DONE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            op_a_q  <= '0;
            op_b_q  <= '0;
            carry_q <= 1'b0;
            sub_q   <= 1'b0;
            cnt_q   <= '0;
            s_q     <= '0;
            rout_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            op_a_q  <= op_a_d;
            op_b_q  <= op_b_d;
            carry_q <= carry_d;
            sub_q   <= sub_d;
            cnt_q   <= cnt_d;
            s_q     <= s_d;
            rout_q  <= rout_d;
            ovf_q   <= ovf_d;
        end
    end

    assign s    = s_q;
    assign rout = rout_q;
    assign ovf  = ovf_q;
    assign busy = (state_q == S_RUN);
    assign done = (state_q == S_DONE);

endmodule

// File: tb/tb_additionneur_serie_param.sv
// Bench for additionneur_serie_param: three configurations (8/2, 16/4, 8/8)
// checked against an integer-arithmetic reference model.
module tb_additionneur_serie_param;

    logic clk;
    logic rst;

    logic        st0, sb0, ri0, ro0, ov0, bz0, dn0;
    logic [7:0]  a0, b0, s0;
    logic        st1, sb1, ri1, ro1, ov1, bz1, dn1;
    logic [15:0] a1, b1, s1;
    logic        st2, sb2, ri2, ro2, ov2, bz2, dn2;
    logic [7:0]  a2, b2, s2;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    int last_done_cyc = 0;

    additionneur_serie_param #(.WIDTH(8), .DIGIT(2)) dut0 (
        .clk(clk), .rst(rst), .start(st0), .sub(sb0), .a(a0), .b(b0), .rin(ri0),
        .s(s0), .rout(ro0), .ovf(ov0), .busy(bz0), .done(dn0));

    additionneur_serie_param #(.WIDTH(16), .DIGIT(4)) dut1 (
        .clk(clk), .rst(rst), .start(st1), .sub(sb1), .a(a1), .b(b1), .rin(ri1),
        .s(s1), .rout(ro1), .ovf(ov1), .busy(bz1), .done(dn1));

    additionneur_serie_param #(.WIDTH(8), .DIGIT(8)) dut2 (
        .clk(clk), .rst(rst), .start(st2), .sub(sb2), .a(a2), .b(b2), .rin(ri2),
        .s(s2), .rout(ro2), .ovf(ov2), .busy(bz2), .done(dn2));

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference: plain integer arithmetic on the operation as stated, not on digits.
    function automatic logic [17:0] model(input int w, input logic [15:0] a, input logic [15:0] b,
                                          input logic sub, input logic rin);
        longint m, ua, ub, ur, full, sa, sb, sr;
        logic   r, o;
        logic [15:0] res;
        m  = longint'(1) << w;
        ua = longint'(a);
        ub = longint'(b);
        ur = longint'(rin);
        full = sub ? (ua - ub - ur) : (ua + ub + ur);
        r    = sub ? (full < 0) : (full >= m);
        res  = 16'(full & (m - 1));
        sa = (ua >= m / 2) ? ua - m : ua;
        sb = (ub >= m / 2) ? ub - m : ub;
        sr = sub ? (sa - sb - ur) : (sa + sb + ur);
        o  = (sr < -(m / 2)) || (sr >= m / 2);
        return {o, r, res};
    endfunction

    task automatic get(input int k, output logic [15:0] so, output logic ro, output logic ov,
                       output logic bz, output logic dn);
        case (k)
            0:       begin so = {8'h00, s0}; ro = ro0; ov = ov0; bz = bz0; dn = dn0; end
            1:       begin so = s1;          ro = ro1; ov = ov1; bz = bz1; dn = dn1; end
            default: begin so = {8'h00, s2}; ro = ro2; ov = ov2; bz = bz2; dn = dn2; end
        endcase
    endtask

    task automatic drive(input int k, input logic [15:0] av, input logic [15:0] bv,
                         input logic sv, input logic rv, input logic stv);
        case (k)
            0:       begin a0 = av[7:0]; b0 = bv[7:0]; sb0 = sv; ri0 = rv; st0 = stv; end
            1:       begin a1 = av;      b1 = bv;      sb1 = sv; ri1 = rv; st1 = stv; end
            default: begin a2 = av[7:0]; b2 = bv[7:0]; sb2 = sv; ri2 = rv; st2 = stv; end
        endcase
    endtask

    // Called at a sample point (#1 after an edge); returns at the done sample point,
    // or one cycle later when pulse_chk is set.
    task automatic op(input int k, input int n, input logic [15:0] a, input logic [15:0] b,
                      input logic sub, input logic rin, input logic [15:0] es, input logic er,
                      input logic eo, input string tag, input bit pulse_chk, input int ignore_at);
        logic [15:0] so, prev;
        logic ro, ov, bz, dn;
        int lat, busy_cnt;
        bit got;
        get(k, prev, ro, ov, bz, dn);
        drive(k, a, b, sub, rin, 1'b1);
        @(posedge clk); #1;
        drive(k, 16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom), 1'b0);
        get(k, so, ro, ov, bz, dn);
        chk({tag, "_busy_start"}, bz, 1'b1);
        chk({tag, "_hold_s"}, so, prev);
        busy_cnt = bz ? 1 : 0;
        lat = 0;
        got = 0;
        for (int c = 0; c < 64 && !got; c++) begin
            @(posedge clk); #1;
            lat++;
            get(k, so, ro, ov, bz, dn);
            if (dn) begin
                got = 1;
            end else begin
                if (bz) busy_cnt++;
                if (ignore_at > 0 && lat == ignore_at)
                    drive(k, ~a, ~b, ~sub, ~rin, 1'b1);
                else if (ignore_at > 0 && lat == ignore_at + 1)
                    drive(k, 16'($urandom), 16'($urandom), 1'b0, 1'b0, 1'b0);
            end
        end
        last_done_cyc = cyc;
        chk({tag, "_done_seen"}, got, 1'b1);
        chk({tag, "_latency"}, lat, n);
        chk({tag, "_busy_cycles"}, busy_cnt, n);
        chk({tag, "_busy_at_done"}, bz, 1'b0);
        chk({tag, "_s"}, so, es);
        chk({tag, "_rout"}, ro, er);
        chk({tag, "_ovf"}, ov, eo);
        if (pulse_chk) begin
            @(posedge clk); #1;
            get(k, so, ro, ov, bz, dn);
            chk({tag, "_done_pulse"}, dn, 1'b0);
            chk({tag, "_s_held"}, so, es);
        end
    endtask

    task automatic rnd_op(input int k, input int w, input int n, input int idx);
        logic [15:0] a, b, msk;
        logic sub, rin;
        logic [17:0] e;
        msk = 16'((longint'(1) << w) - 1);
        a   = 16'($urandom) & msk;
        b   = 16'($urandom) & msk;
        sub = 1'($urandom);
        rin = 1'($urandom);
        e   = model(w, a, b, sub, rin);
        op(k, n, a, b, sub, rin, e[15:0], e[16], e[17], $sformatf("rnd%0d_%0d", k, idx), 1, 0);
    endtask

    initial begin
        logic [15:0] so;
        logic ro, ov, bz, dn;
        int first_done;
        bit seen_done, seen_busy;

        rst = 1'b1;
        for (int k = 0; k < 3; k++) drive(k, 16'h0, 16'h0, 1'b0, 1'b0, 1'b0);
        @(posedge clk); #1;
        get(0, so, ro, ov, bz, dn);
        chk("reset_s", so, 16'h0);
        chk("reset_flags", {ro, ov, bz, dn}, 4'b0000);
        @(posedge clk); #3;
        rst = 1'b0;
        @(posedge clk); #1;

        op(0, 4, 16'hC9, 16'h0C, 0, 0, 16'hD5, 0, 0, "add_c9_0c", 1, 0);
        op(0, 4, 16'hC9, 16'h4B, 0, 0, 16'h14, 1, 0, "add_c9_4b", 1, 0);
        op(0, 4, 16'h7F, 16'h01, 0, 0, 16'h80, 0, 1, "add_ovf", 1, 0);
        op(0, 4, 16'h05, 16'h07, 1, 0, 16'hFE, 1, 0, "sub_borrow", 1, 0);
        op(0, 4, 16'h80, 16'h01, 1, 0, 16'h7F, 0, 1, "sub_ovf", 1, 0);
        op(0, 4, 16'h10, 16'h01, 1, 1, 16'h0E, 0, 0, "sub_rin", 1, 0);

        op(0, 4, 16'hC9, 16'h0C, 0, 0, 16'hD5, 0, 0, "ignore_mid_start", 1, 2);

        op(0, 4, 16'h12, 16'h34, 0, 0, 16'h46, 0, 0, "b2b_first", 0, 0);
        first_done = last_done_cyc;
        op(0, 4, 16'h50, 16'h20, 1, 0, 16'h30, 0, 0, "b2b_second", 1, 0);
        chk("b2b_spacing", last_done_cyc - first_done, 5);

        drive(0, 16'h33, 16'h44, 1'b0, 1'b0, 1'b1);
        @(posedge clk); #1;
        drive(0, 16'h00, 16'h00, 1'b0, 1'b0, 1'b0);
        @(posedge clk); #3;
        rst = 1'b1;
        #1;
        get(0, so, ro, ov, bz, dn);
        chk("midrun_reset_s", so, 16'h0);
        chk("midrun_reset_flags", {ro, ov, bz, dn}, 4'b0000);
        #3;
        rst = 1'b0;
        seen_done = 0;
        seen_busy = 0;
        for (int c = 0; c < 8; c++) begin
            @(posedge clk); #1;
            get(0, so, ro, ov, bz, dn);
            seen_done |= dn;
            seen_busy |= bz;
        end
        chk("no_done_after_reset", seen_done, 1'b0);
        chk("no_busy_after_reset", seen_busy, 1'b0);
        op(0, 4, 16'h01, 16'h01, 0, 0, 16'h02, 0, 0, "after_reset", 1, 0);

        op(1, 4, 16'hFFFF, 16'h0001, 0, 1, 16'h0001, 1, 0, "w16_add", 1, 0);
        op(2, 1, 16'hC9, 16'h0C, 0, 0, 16'hD5, 0, 0, "d8_add", 1, 0);

        for (int i = 0; i < 12; i++) rnd_op(0, 8, 4, i);
        for (int i = 0; i < 6; i++)  rnd_op(1, 16, 4, i);
        for (int i = 0; i < 6; i++)  rnd_op(2, 8, 1, i);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
